// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter
// Two-master arbiter in front of the single load/store unit port.
//   Master 0: core memory stage. Master 1: debug/loader port.
// Round-robin arbitration with a bounded burst. Each master gets its load data
// back through its own register, valid for exactly one cycle after the grant.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   mX_req_i                   transfer request, held with qualifiers until granted
//   mX_we_i                    store (1) / load (0)
//   mX_addr_i                  byte address
//   mX_func3_i                 access size/sign (RV32 func3)
//   mX_wdata_i                 store data
//   mX_gnt_o                   transfer accepted this cycle
//   mX_rvalid_o                load data valid (1-cycle pulse)
//   mX_rdata_o                 load data, held until the next load by that master
//   lsu_addr_o, lsu_func3_o,
//   lsu_st_data_o, lsu_st_en_o request muxed from the granted master, zero otherwise
//   lsu_ld_data_i              combinational load data from the LSU

module lsu_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [2:0]        m0_func3_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [2:0]        m1_func3_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,

    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic [2:0]        lsu_func3_o,
    output logic [31:0]       lsu_st_data_o,
    output logic              lsu_st_en_o,
    input  logic [31:0]       lsu_ld_data_i
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e     state_q, state_d;
    logic [3:0] burst_q, burst_d;
    // Last master granted: 0 = M0, 1 = M1.
    logic       last_q, last_d;

    logic       gnt0, gnt1;

    logic        rvalid0_q, rvalid1_q;
    logic [31:0] rdata0_q, rdata1_q;

    // ------------------------------------------------------------------
    // Grant decision and next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Tie goes to whoever was not served last.
                if (m0_req_i && (!m1_req_i || last_q)) begin
                    gnt0 = 1'b1;
                end else if (m1_req_i) begin
                    gnt1 = 1'b1;
                end
            end
            StOwn0: begin
                // Owner keeps the bus until its burst is used up while M1 waits.
                if (m0_req_i && (!m1_req_i || (burst_q < MaxBurst))) begin
                    gnt0 = 1'b1;
                end else if (m1_req_i) begin
                    gnt1 = 1'b1;
                end
            end
            StOwn1: begin
                if (m1_req_i && (!m0_req_i || (burst_q < MaxBurst))) begin
                    gnt1 = 1'b1;
                end else if (m0_req_i) begin
                    gnt0 = 1'b1;
                end
            end
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase

        // No transfer may reach the LSU while reset is held.
        if (rst_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            state_d = StOwn0;
            last_d  = 1'b0;
            if (state_q == StOwn0) begin
                burst_d = (burst_q < MaxBurst) ? burst_q + 4'd1 : burst_q;
            end else begin
                burst_d = 4'd1;
            end
        end else if (gnt1) begin
            state_d = StOwn1;
            last_d  = 1'b1;
            if (state_q == StOwn1) begin
                burst_d = (burst_q < MaxBurst) ? burst_q + 4'd1 : burst_q;
            end else begin
                burst_d = 4'd1;
            end
        end else begin
            state_d = StIdle;
            burst_d = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // LSU request mux
    // ------------------------------------------------------------------
    always_comb begin
        lsu_addr_o    = '0;
        lsu_func3_o   = 3'd0;
        lsu_st_data_o = 32'd0;
        lsu_st_en_o   = 1'b0;
        if (gnt0) begin
            lsu_addr_o    = m0_addr_i;
            lsu_func3_o   = m0_func3_i;
            lsu_st_data_o = m0_wdata_i;
            lsu_st_en_o   = m0_we_i;
        end else if (gnt1) begin
            lsu_addr_o    = m1_addr_i;
            lsu_func3_o   = m1_func3_i;
            lsu_st_data_o = m1_wdata_i;
            lsu_st_en_o   = m1_we_i;
        end
    end

    // ------------------------------------------------------------------
    // State and load-response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            burst_q   <= 4'd0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            rvalid0_q <= gnt0 && !m0_we_i;
            rvalid1_q <= gnt1 && !m1_we_i;
            if (gnt0 && !m0_we_i) begin
                rdata0_q <= lsu_ld_data_i;
            end
            if (gnt1 && !m1_we_i) begin
                rdata1_q <= lsu_ld_data_i;
            end
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = rvalid0_q;
    assign m1_rvalid_o = rvalid1_q;
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
module tb_lsu_bus_arbiter;

    localparam int unsigned MaxBurst = 4;
    localparam int unsigned AddrW    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             m0_req, m0_we, m1_req, m1_we;
    logic [AddrW-1:0] m0_addr, m1_addr;
    logic [2:0]       m0_func3, m1_func3;
    logic [31:0]      m0_wdata, m1_wdata;
    logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]      m0_rdata, m1_rdata;
    logic [AddrW-1:0] lsu_addr;
    logic [2:0]       lsu_func3;
    logic [31:0]      lsu_st_data, lsu_ld_data;
    logic             lsu_st_en;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_bus_arbiter #(
        .MAX_BURST(MaxBurst),
        .ADDR_W   (AddrW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m0_req_i     (m0_req),
        .m0_we_i      (m0_we),
        .m0_addr_i    (m0_addr),
        .m0_func3_i   (m0_func3),
        .m0_wdata_i   (m0_wdata),
        .m0_gnt_o     (m0_gnt),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rdata_o   (m0_rdata),
        .m1_req_i     (m1_req),
        .m1_we_i      (m1_we),
        .m1_addr_i    (m1_addr),
        .m1_func3_i   (m1_func3),
        .m1_wdata_i   (m1_wdata),
        .m1_gnt_o     (m1_gnt),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rdata_o   (m1_rdata),
        .lsu_addr_o   (lsu_addr),
        .lsu_func3_o  (lsu_func3),
        .lsu_st_data_o(lsu_st_data),
        .lsu_st_en_o  (lsu_st_en),
        .lsu_ld_data_i(lsu_ld_data)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_func3 = 3'd0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_func3 = 3'd0; m1_wdata = '0;
        lsu_ld_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic             r0, we0;
        logic [AddrW-1:0] a0;
        logic             r1, we1;
        logic [AddrW-1:0] a1;
        logic [31:0]      wd1, ld;
        logic             g0, g1, v0, v1;
        logic [31:0]      d0, d1;
        logic             st;
        logic [AddrW-1:0] addr;
        logic [31:0]      wd;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(
        logic r0, logic we0, logic [AddrW-1:0] a0,
        logic r1, logic we1, logic [AddrW-1:0] a1, logic [31:0] wd1, logic [31:0] ld,
        logic g0, logic g1, logic v0, logic v1, logic [31:0] d0, logic [31:0] d1,
        logic st, logic [AddrW-1:0] addr, logic [31:0] wd);
        vec_t v;
        v.r0 = r0; v.we0 = we0; v.a0 = a0;
        v.r1 = r1; v.we1 = we1; v.a1 = a1; v.wd1 = wd1; v.ld = ld;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
        v.st = st; v.addr = addr; v.wd = wd;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: arbitration described by grant history
    // ------------------------------------------------------------------
    int          m_prev;   // master granted in the previous cycle, -1 if none
    int          m_run;    // length of the current unbroken run of grants to m_prev
    int          m_last;   // most recent master ever granted since reset
    logic        m_v0, m_v1;
    logic [31:0] m_d0, m_d1;

    task automatic model_reset();
        m_prev = -1; m_run = 0; m_last = 1;
        m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0;
    endtask

    function automatic int model_pick(logic r, logic q0, logic q1);
        if (r) return -1;
        if (q0 && !q1) return 0;
        if (q1 && !q0) return 1;
        if (!q0 && !q1) return -1;
        if (m_prev < 0) return 1 - m_last;
        if (m_run >= int'(MaxBurst)) return 1 - m_prev;
        return m_prev;
    endfunction

    task automatic model_step(int g);
        if (rst) begin
            model_reset();
            return;
        end
        m_v0 = (g == 0) && !m0_we;
        m_v1 = (g == 1) && !m1_we;
        if (m_v0) m_d0 = lsu_ld_data;
        if (m_v1) m_d1 = lsu_ld_data;
        if (g >= 0) begin
            m_run  = (g == m_prev) ? m_run + 1 : 1;
            m_prev = g;
            m_last = g;
        end else begin
            m_prev = -1;
            m_run  = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Table fill
        tab.push_back(mk(1, 0, 12'h004, 0, 0, 0, 0, 32'hDEADBEEF,
                         1, 0, 0, 0, 0, 0, 0, 12'h004, 32'h55));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 1, 12'h400, 32'h3F, 0,
                         0, 1, 0, 0, 32'hDEADBEEF, 0, 1, 12'h400, 32'h3F));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            logic g0;
            g0 = (i < 4) || (i >= 8);
            tab.push_back(mk(1, 0, 12'h010, 1, 0, 12'h020, 32'h77, 32'hCAFE0000,
                             g0, !g0, ((i >= 1) && (i <= 4)) || (i >= 9), (i >= 5) && (i <= 8),
                             (i >= 1) ? 32'hCAFE0000 : 32'hDEADBEEF,
                             (i >= 5) ? 32'hCAFE0000 : 32'h0,
                             0, g0 ? 12'h010 : 12'h020, g0 ? 32'h55 : 32'h77));
        end
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 0, 32'hCAFE0000, 32'hCAFE0000, 0, 0, 0));
        for (int j = 0; j < 6; j++) begin
            tab.push_back(mk(1, 0, 12'h010, 0, 0, 0, 0, 32'h0BAD0000,
                             1, 0, j >= 1, 0, (j >= 1) ? 32'h0BAD0000 : 32'hCAFE0000,
                             32'hCAFE0000, 0, 12'h010, 32'h55));
        end
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 1, 0, 32'h0BAD0000, 32'hCAFE0000, 0, 0, 0));

        // Directed table
        do_reset();
        for (int i = 0; i < tab.size(); i++) begin
            logic [2:0] ef3;
            m0_req = tab[i].r0; m0_we = tab[i].we0; m0_addr = tab[i].a0;
            m0_func3 = 3'b010; m0_wdata = 32'h55;
            m1_req = tab[i].r1; m1_we = tab[i].we1; m1_addr = tab[i].a1;
            m1_func3 = 3'b001; m1_wdata = tab[i].wd1;
            lsu_ld_data = tab[i].ld;
            ef3 = tab[i].g0 ? 3'b010 : (tab[i].g1 ? 3'b001 : 3'b000);
            @(negedge clk);
            chk($sformatf("t%0d m0_gnt", i), 32'(m0_gnt), 32'(tab[i].g0));
            chk($sformatf("t%0d m1_gnt", i), 32'(m1_gnt), 32'(tab[i].g1));
            chk($sformatf("t%0d m0_rvalid", i), 32'(m0_rvalid), 32'(tab[i].v0));
            chk($sformatf("t%0d m1_rvalid", i), 32'(m1_rvalid), 32'(tab[i].v1));
            chk($sformatf("t%0d m0_rdata", i), m0_rdata, tab[i].d0);
            chk($sformatf("t%0d m1_rdata", i), m1_rdata, tab[i].d1);
            chk($sformatf("t%0d st_en", i), 32'(lsu_st_en), 32'(tab[i].st));
            chk($sformatf("t%0d addr", i), 32'(lsu_addr), 32'(tab[i].addr));
            chk($sformatf("t%0d st_data", i), lsu_st_data, tab[i].wd);
            chk($sformatf("t%0d func3", i), 32'(lsu_func3), 32'(ef3));
            @(posedge clk);
            #1;
        end

        // Reset asserted on what would be the 2nd M0 grant of a contended burst
        do_reset();
        m0_req = 1; m0_addr = 12'h030; m0_func3 = 3'b010;
        m1_req = 1; m1_addr = 12'h040; m1_func3 = 3'b010;
        lsu_ld_data = 32'h12345678;
        @(negedge clk);
        chk("rst c0 m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rst c0 m1_gnt", 32'(m1_gnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        lsu_ld_data = 32'h9ABCDEF0;
        @(negedge clk);
        chk("rst c1 m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst c1 m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst c1 st_en", 32'(lsu_st_en), 32'd0);
        chk("rst c1 m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rst c1 m0_rdata", m0_rdata, 32'h12345678);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst c2 m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst c2 m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst c2 m0_rdata", m0_rdata, 32'h0);
        chk("rst c2 m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rst c2 m1_gnt", 32'(m1_gnt), 32'd0);
        @(posedge clk);
        #1;

        // M1 withdraws its store request while M0 bursts
        do_reset();
        m0_req = 1; m0_addr = 12'h020; m0_func3 = 3'b010;
        m1_we = 1; m1_addr = 12'h400; m1_wdata = 32'hFF;
        for (int k = 0; k < 8; k++) begin
            m1_req = (k == 1) || (k == 2);
            @(negedge clk);
            chk($sformatf("wd%0d m0_gnt", k), 32'(m0_gnt), 32'd1);
            chk($sformatf("wd%0d m1_gnt", k), 32'(m1_gnt), 32'd0);
            chk($sformatf("wd%0d st_en", k), 32'(lsu_st_en), 32'd0);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int          g;
            logic [31:0] ea, ef, ew;
            logic        es;
            rst      = ($urandom_range(0, 99) == 0);
            m0_req   = ($urandom_range(0, 9) < 7);
            m1_req   = ($urandom_range(0, 9) < 7);
            m0_we    = $urandom_range(0, 1) == 1;
            m1_we    = $urandom_range(0, 1) == 1;
            m0_addr  = AddrW'($urandom);
            m1_addr  = AddrW'($urandom);
            m0_func3 = 3'($urandom);
            m1_func3 = 3'($urandom);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            lsu_ld_data = $urandom;
            g  = model_pick(rst, m0_req, m1_req);
            ea = (g == 0) ? 32'(m0_addr)  : (g == 1) ? 32'(m1_addr)  : 32'd0;
            ef = (g == 0) ? 32'(m0_func3) : (g == 1) ? 32'(m1_func3) : 32'd0;
            ew = (g == 0) ? m0_wdata      : (g == 1) ? m1_wdata      : 32'd0;
            es = (g == 0) ? m0_we         : (g == 1) ? m1_we         : 1'b0;
            @(negedge clk);
            chk($sformatf("r%0d m0_gnt", c), 32'(m0_gnt), 32'(g == 0));
            chk($sformatf("r%0d m1_gnt", c), 32'(m1_gnt), 32'(g == 1));
            chk($sformatf("r%0d addr", c), 32'(lsu_addr), ea);
            chk($sformatf("r%0d func3", c), 32'(lsu_func3), ef);
            chk($sformatf("r%0d st_data", c), lsu_st_data, ew);
            chk($sformatf("r%0d st_en", c), 32'(lsu_st_en), 32'(es));
            chk($sformatf("r%0d m0_rvalid", c), 32'(m0_rvalid), 32'(m_v0));
            chk($sformatf("r%0d m1_rvalid", c), 32'(m1_rvalid), 32'(m_v1));
            chk($sformatf("r%0d m0_rdata", c), m0_rdata, m_d0);
            chk($sformatf("r%0d m1_rdata", c), m1_rdata, m_d1);
            @(posedge clk);
            model_step(g);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
